strobe_window_count: RTL and testbench
======================================

STROBE_WINDOW_COUNT -- requirements
Module: strobe_window_count

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the per-window event count.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of buffered window results; power of 2, at least 2.
REQ-003 SHALL have parameter DROP_W, default 8, width of the dropped-window counter.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port i_cg, input, 1, clock-gate enable; all state holds when low.
REQ-007 SHALL have port i_strobe, input, 1, single-cycle window-close pulse from the strobe generator.
REQ-008 SHALL have port i_event, input, 1, event to count; one count per high cycle.
REQ-009 SHALL have port o_data, output, CNT_W, head-of-buffer window count.
REQ-010 SHALL have port o_saturated, output, 1, head-of-buffer flag: count hit all-ones during that window.
REQ-011 SHALL have port o_valid, output, 1, buffer non-empty.
REQ-012 SHALL have port i_ready, input, 1, consumer accepts head entry.
REQ-013 SHALL have port o_dropCount, output, DROP_W, number of window results lost to a full buffer.
REQ-014 SHALL have port i_clearDrops, input, 1, synchronous clear of o_dropCount.

Function
REQ-015 SHALL update no state in any cycle with i_cg low; i_strobe, i_event, i_ready and i_clearDrops are ignored in that cycle.
REQ-016 SHALL keep accumulator acc (CNT_W bits) plus sticky flag sat; on a cycle with i_cg high and i_strobe low, acc increments by 1 when i_event is high.
REQ-017 SHALL saturate acc at all-ones: no wrap; sat set when an increment is attempted at all-ones or acc reaches all-ones.
REQ-018 SHALL, on a cycle with i_cg high and i_strobe high (window close), form result count = acc + i_event, saturating; flag = sat OR saturation in this cycle.
REQ-019 SHALL, on window close, reset acc to 0 and sat to 0 in the same edge; an i_event in the close cycle belongs to the closing window only.
REQ-020 SHALL push the result into a FIFO of FIFO_DEPTH entries, {flag, count} per entry.
REQ-021 SHALL pop when i_cg, o_valid and i_ready are all high.
REQ-022 SHALL present a pushed result on o_data/o_saturated with o_valid high one cycle after the close cycle when the FIFO was empty; no combinational strobe-to-output path.
REQ-023 SHALL hold o_data and o_saturated stable while o_valid is high and i_ready is low.
REQ-024 SHALL accept a push when full if a pop occurs in the same cycle: occupancy unchanged, no drop.
REQ-025 SHALL, on push when full with no pop, discard the new result, leave FIFO contents unchanged, and increment o_dropCount.
REQ-026 SHALL saturate o_dropCount at all-ones.
REQ-027 SHALL give i_clearDrops priority as: clear and drop in the same cycle -> o_dropCount = 1; clear alone -> 0.
REQ-028 SHALL use read/write pointers one bit wider than log2(FIFO_DEPTH) to distinguish full from empty; the pointers wrap modulo 2*FIFO_DEPTH.
REQ-029 SHALL drive o_data and o_saturated to 0 when o_valid is low.

Reset
REQ-030 SHALL, while i_rst is high, force acc=0, sat=0, FIFO empty (o_valid=0), o_data=0, o_saturated=0, o_dropCount=0, independent of i_clk and i_cg.
REQ-031 SHALL discard partial window counts and buffered entries on reset mid-operation; the first window after reset release counts from the first edge with i_cg high.

Verification
REQ-032 SHALL cover basic count: CNT_W=16; 5 event cycles, then i_strobe with i_event low; i_ready=1 -> o_valid=1 next cycle with o_data=5, o_saturated=0, for exactly one cycle.
REQ-033 SHALL cover close-cycle event: i_event high in 3 cycles including the strobe cycle -> o_data=3; following window starts at 0.
REQ-034 SHALL cover saturation: CNT_W=4; 20 consecutive event cycles then strobe -> o_data=15, o_saturated=1; next window of 2 events -> o_data=2, o_saturated=0.
REQ-035 SHALL cover backpressure: FIFO_DEPTH=2, i_ready=0; 3 strobes with counts 1,2,3 -> entries 1,2 retained, o_dropCount=1; i_ready=1 -> 1 then 2 in order, then o_valid=0.
REQ-036 SHALL cover full with simultaneous pop: FIFO full and i_ready=1 in a strobe cycle -> no drop, occupancy stays 2; also i_clearDrops plus a drop in the same cycle -> o_dropCount=1.
REQ-037 SHALL cover gating and reset: i_cg=0 with i_strobe and i_event high -> no state change; i_rst asserted mid-window with 2 entries buffered -> o_valid=0 and o_dropCount=0 immediately, without a clock edge.

Source files
------------

// File: rtl/strobe_window_count.sv
// ---------------------------------------------------------------------------
// strobe_window_count
//   Counts i_event cycles between window-close strobes. Each closed window
//   produces a {saturated, count} result, which is buffered in a small FIFO
//   for a ready/valid consumer. Results that arrive when the buffer is full
//   and not draining are discarded and tallied in a saturating drop counter.
//
// Ports
//   i_clk          sole clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_cg           clock-gate enable; nothing changes while low
//   i_strobe       single-cycle window-close pulse
//   i_event        event to count, one count per high cycle
//   o_data         head-of-buffer window count (0 when empty)
//   o_saturated    head-of-buffer saturation flag (0 when empty)
//   o_valid        buffer non-empty
//   i_ready        consumer accepts the head entry
//   o_dropCount    number of results lost to a full buffer (saturating)
//   i_clearDrops   synchronous clear of o_dropCount
// ---------------------------------------------------------------------------
module strobe_window_count #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int DROP_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cg,
  input  logic              i_strobe,
  input  logic              i_event,
  output logic [CNT_W-1:0]  o_data,
  output logic              o_saturated,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DROP_W-1:0] o_dropCount,
  input  logic              i_clearDrops
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic             flag;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  entry_t            mem_q [FIFO_DEPTH];

  logic       acc_at_max;
  logic [CNT_W-1:0] acc_inc;
  logic       inc_hits_max;
  entry_t     res;
  entry_t     head;
  logic       empty, full, pop, push, wr_en, drop;

  // Saturating increment: the adder never sees an increment at all-ones.
  // acc_inc == max covers both "reached all-ones" and "attempted past it".
  assign acc_at_max   = (acc_q == CNT_MAX);
  assign acc_inc      = acc_q + CNT_W'(i_event & ~acc_at_max);
  assign inc_hits_max = (acc_inc == CNT_MAX);

  // The close-cycle event belongs to the closing window.
  assign res.cnt  = acc_inc;
  assign res.flag = sat_q | inc_hits_max;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop   = i_cg & ~empty & i_ready;
  assign push  = i_cg & i_strobe;
  // A full buffer that pops this cycle frees the slot being written.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    acc_d    = acc_q;
    sat_d    = sat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (i_cg) begin
      if (i_strobe) begin
        acc_d = '0;
        sat_d = 1'b0;
      end else begin
        acc_d = acc_inc;
        sat_d = sat_q | inc_hits_max;
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      // Clear wins over history, but a drop in the same cycle still counts.
      if (i_clearDrops)
        drop_d = drop ? DROP_W'(1) : '0;
      else if (drop && drop_q != DROP_MAX)
        drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: outputs are masked by o_valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= res;
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign o_valid     = ~empty;
  assign o_data      = o_valid ? head.cnt  : '0;
  assign o_saturated = o_valid ? head.flag : 1'b0;
  assign o_dropCount = drop_q;

endmodule

// File: tb/tb_strobe_window_count.sv
module tb_strobe_window_count;

  logic clk = 1'b0;
  logic rst, cg, str, ev, rdy, clr;

  logic [15:0] a_data;  logic a_sat, a_valid;  logic [7:0] a_drop;
  logic [3:0]  b_data;  logic b_sat, b_valid;  logic [7:0] b_drop;

  always #5 clk = ~clk;

  strobe_window_count #(.CNT_W(16), .FIFO_DEPTH(2), .DROP_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_strobe(str), .i_event(ev),
    .o_data(a_data), .o_saturated(a_sat), .o_valid(a_valid), .i_ready(rdy),
    .o_dropCount(a_drop), .i_clearDrops(clr));

  strobe_window_count #(.CNT_W(4), .FIFO_DEPTH(2), .DROP_W(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_strobe(str), .i_event(ev),
    .o_data(b_data), .o_saturated(b_sat), .o_valid(b_valid), .i_ready(rdy),
    .o_dropCount(b_drop), .i_clearDrops(clr));

  // Reference state: index 0 models dut_a (16-bit), index 1 dut_b (4-bit).
  int          m_acc [2];
  bit          m_sat [2];
  int          m_drop[2];
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_sat[k] = 0; m_drop[k] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step(input int k);
    int mx, cnt, occ;
    bit flag, pop, full, dropev;
    logic [16:0] ent;
    if (!cg) return;
    mx     = (k == 0) ? 65535 : 15;
    occ    = (k == 0) ? qa.size() : qb.size();
    pop    = rdy && (occ != 0);
    full   = (occ == 2);
    dropev = str && full && !pop;
    cnt    = 0;
    flag   = 0;
    if (str) begin
      cnt = m_acc[k] + (ev ? 1 : 0);
      if (cnt > mx) cnt = mx;
      flag = m_sat[k] || (cnt == mx);
      m_acc[k] = 0;
      m_sat[k] = 0;
    end else if (ev) begin
      if (m_acc[k] < mx) m_acc[k]++;
      if (m_acc[k] == mx) m_sat[k] = 1;
    end
    ent = {flag, cnt[15:0]};
    if (k == 0) begin
      if (pop) void'(qa.pop_front());
      if (str && !dropev) qa.push_back(ent);
    end else begin
      if (pop) void'(qb.pop_front());
      if (str && !dropev) qb.push_back(ent);
    end
    if (clr) m_drop[k] = dropev ? 1 : 0;
    else if (dropev && m_drop[k] < 255) m_drop[k]++;
  endtask

  task automatic check_outs();
    logic [16:0] ha, hb;
    ha = (qa.size() != 0) ? qa[0] : 17'd0;
    hb = (qb.size() != 0) ? qb[0] : 17'd0;
    chk("a_valid", a_valid, qa.size() != 0);
    chk("a_data",  a_data,  ha[15:0]);
    chk("a_sat",   a_sat,   ha[16]);
    chk("a_drop",  a_drop,  m_drop[0]);
    chk("b_valid", b_valid, qb.size() != 0);
    chk("b_data",  b_data,  hb[15:0]);
    chk("b_sat",   b_sat,   hb[16]);
    chk("b_drop",  b_drop,  m_drop[1]);
  endtask

  // Drive inputs, clock once, update the reference, sample 1ns later.
  task automatic tick(input bit c, input bit s, input bit e, input bit r, input bit cl);
    cg = c; str = s; ev = e; rdy = r; clr = cl;
    @(posedge clk);
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_outs();
  endtask

  initial begin
    rst = 1'b1; cg = 1'b0; str = 1'b0; ev = 1'b0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    // Reset holds everything regardless of activity.
    repeat (2) tick(1, 1, 1, 1, 0);
    rst = 1'b0;

    // Basic count: 5 events, strobe with event low.
    repeat (5) tick(1, 0, 1, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk("basic_valid", a_valid, 1);
    chk("basic_data",  a_data,  5);
    chk("basic_sat",   a_sat,   0);
    tick(1, 0, 0, 1, 0);
    chk("basic_one_cycle", a_valid, 0);

    // Event in the close cycle belongs to the closing window.
    repeat (2) tick(1, 0, 1, 1, 0);
    tick(1, 1, 1, 1, 0);
    chk("close_ev_data", a_data, 3);
    tick(1, 0, 0, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk("next_window_zero", a_data, 0);
    tick(1, 0, 0, 1, 0);

    // Saturation on the 4-bit instance.
    repeat (20) tick(1, 0, 1, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk("sat_b_data", b_data, 15);
    chk("sat_b_flag", b_sat,  1);
    chk("sat_a_data", a_data, 20);
    tick(1, 0, 0, 1, 0);
    repeat (2) tick(1, 0, 1, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk("sat_after_data", b_data, 2);
    chk("sat_after_flag", b_sat,  0);
    tick(1, 0, 0, 1, 0);

    // Backpressure: windows of 1, 2, 3 with no consumer.
    for (int w = 1; w <= 3; w++) begin
      repeat (w) tick(1, 0, 1, 0, 0);
      tick(1, 1, 0, 0, 0);
    end
    chk("bp_drop", a_drop, 1);
    chk("bp_head", a_data, 1);
    tick(1, 0, 0, 1, 0);
    chk("bp_second", a_data, 2);
    tick(1, 0, 0, 1, 0);
    chk("bp_empty", a_valid, 0);

    // Full with simultaneous pop, then clear-with-drop.
    tick(1, 1, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 1, 0);
    chk("fullpop_drop", a_drop, 1);
    chk("fullpop_head", a_data, 0);
    tick(1, 0, 0, 0, 0);
    chk("hold_stable", a_data, 0);
    tick(1, 1, 0, 0, 1);
    chk("clr_and_drop", a_drop, 1);
    tick(1, 0, 0, 0, 1);
    chk("clr_alone", a_drop, 0);
    tick(1, 0, 0, 1, 0);
    chk("fullpop_tail", a_data, 1);
    tick(1, 0, 0, 1, 0);
    chk("fullpop_occ2", a_valid, 0);

    // Drop counter saturates.
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    repeat (260) tick(1, 1, 0, 0, 0);
    chk("drop_sat", a_drop, 255);
    tick(1, 0, 0, 0, 1);
    repeat (2) tick(1, 0, 0, 1, 0);

    // Gating and asynchronous reset mid-window.
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    repeat (3) tick(0, 1, 1, 1, 1);
    chk("gate_drop", a_drop, 1);
    chk("gate_head", a_data, 1);
    tick(1, 0, 1, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_valid", a_valid, 0);
    chk("rst_async_drop",  a_drop,  0);
    chk("rst_async_data",  a_data,  0);
    tick(1, 1, 1, 1, 0);
    rst = 1'b0;
    repeat (2) tick(1, 0, 1, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk("post_rst_a", a_data, 2);
    chk("post_rst_b", b_data, 2);
    tick(1, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
